uart_rx_hexparse: RTL and testbench
===================================

# uart_rx_hexparse

Receive-side ASCII hex token parser, the counterpart of `uart_tx_hexdump`. It sits behind `uart_rx`, consuming its `data`/`data_strobe` byte stream, and accumulates hex digits into a 32-bit word. On each whitespace terminator it emits the word, digit count and terminator type as a one-cycle strobe. Malformed tokens are dropped with an error pulse, so host-side debug commands can be typed or scripted over the serial port.

## Interface
- `MAX_DIGITS`, default 8: maximum hex digits per token; legal range 1..8.
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `uart_rxd_strobe`  input  1  one-cycle pulse: a received byte is valid on `uart_rxd`.
- `uart_rxd`  input  8  received byte, sampled only when `uart_rxd_strobe`=1.
- `strobe`  output  1  one-cycle pulse: a complete token is on `data`/`len`/`space`/`newline`.
- `data`  output  32  parsed value, right-aligned, zero-extended.
- `len`  output  4  number of digits in the token (1..MAX_DIGITS).
- `space`  output  1  token was terminated by space (0x20) or tab (0x09).
- `newline`  output  1  token was terminated by LF (0x0A) or CR (0x0D).
- `error`  output  1  one-cycle pulse: the current token was rejected.

## Operation
- Byte classes:
  - DIGIT: `0`-`9`, `a`-`f`, `A`-`F`, decoded to 4 bits.
  - TERM: 0x20, 0x09, 0x0A, 0x0D.
  - OTHER: every remaining byte value.
- States: IDLE, DIGITS, SKIP. The parser acts only on cycles with `uart_rxd_strobe`=1.
- IDLE:
  - DIGIT → `acc`=digit, `count`=1, go to DIGITS.
  - TERM → ignored; there is no empty-token strobe.
  - OTHER → `error` pulse, go to SKIP.
- DIGITS:
  - DIGIT with `count`<MAX_DIGITS → `acc`={acc[27:0],digit}, `count`+1.
  - DIGIT with `count`=MAX_DIGITS → `error` pulse, go to SKIP (overflow).
  - TERM → load `data`=acc, `len`=count, `space`/`newline` from the terminator class, pulse `strobe`, go to IDLE.
  - OTHER → `error` pulse, go to SKIP.
- SKIP:
  - DIGIT or OTHER → discarded, with no further `error` pulses.
  - TERM → go to IDLE, no `strobe`.
- `error` pulses at most once per rejected token.
- Width rules:
  - `acc` is 32 bits; with MAX_DIGITS<8 the upper bits stay zero.
  - `count` is 4 bits and never exceeds MAX_DIGITS.
- `data`, `len`, `space`, `newline` hold their value until the next `strobe`. `space` and `newline` are mutually exclusive.

## Timing
- Reset values: state=IDLE, `acc`=0, `count`=0, `strobe`=0, `error`=0, `data`=0, `len`=0, `space`=0, `newline`=0.
- Latency:
  - `strobe` and its outputs are registered one cycle after the terminator's `uart_rxd_strobe` cycle.
  - `error` likewise pulses one cycle after the offending byte.
- Back-to-back `uart_rxd_strobe` on consecutive cycles is fully supported; each byte is processed in its own cycle. There is no backpressure, and the consumer must accept `strobe` on the cycle it is high.
- Reset takes priority over `uart_rxd_strobe` in the same cycle: the byte is dropped, and any partial token and pending pulses are cleared.
- `uart_rxd` is ignored when `uart_rxd_strobe`=0.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants (SPACE, TAB, LF, CR).
  - State encoding for IDLE/DIGITS/SKIP.
  - `hexvalue` function (byte → {is_digit, nibble}), the inverse of the existing `hexdigit`.
- One natural sub-module: `ascii_classify`, a combinational classifier that takes `uart_rxd` and outputs `is_digit`, `nibble`, `is_space`, `is_newline`. It is reused by future command parsers.
- No FIFO inside; downstream buffering goes through `fifo_bram` when needed.

## Test plan
- "DEADbeef\n" at 1-cycle spacing → one `strobe` after the LF, `data`=0xDEADBEEF, `len`=8, `newline`=1, `space`=0.
- "1f " → `data`=0x0000001F, `len`=2, `space`=1. A following "  \r\n" produces no strobe and no error.
- "123456789 7\n" → `error` once, on the 9th digit; no strobe for that token. Then `data`=0x7, `len`=1, `newline`=1.
- "12G45 " → `error` after `G`, no strobe; outputs retain their previous values.
- "AB", then `reset` pulse, then "C\n" → single `strobe`, `data`=0xC, `len`=1. All outputs read 0 during and after reset until that strobe.
- MAX_DIGITS=4: "FFFF\t" → `data`=0xFFFF, `len`=4, `space`=1; "FFFFF " → `error`, no strobe.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared ASCII constants, hex-parser state encoding and hex decode helper
package uart_pkg;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  typedef enum logic [1:0] {IDLE, DIGITS, SKIP} state_t;
  // returns {is_digit, nibble}; nibble is 0 for non-digits
  function automatic logic [4:0] hexvalue(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ? {1'b1, b[3:0]} :
           ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) ? {1'b1, b[3:0] + 4'd9} :
           5'd0;
  endfunction
endpackage

// File: rtl/ascii_classify.sv
// ascii_classify: combinational byte classifier for hex digits and whitespace terminators
module ascii_classify
  import uart_pkg::*;
(
  input  logic [7:0] c,
  output logic       is_digit,
  output logic [3:0] nibble,
  output logic       is_space,
  output logic       is_newline
);
  assign {is_digit, nibble} = hexvalue(c);
  assign is_space = (c == SPACE) || (c == TAB);
  assign is_newline = (c == LF) || (c == CR);
endmodule

// File: rtl/uart_rx_hexparse.sv
// uart_rx_hexparse: accumulates ASCII hex tokens from a UART byte stream into 32-bit words
module uart_rx_hexparse
  import uart_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd_strobe,
  input  logic [7:0]  uart_rxd,
  output logic        strobe,
  output logic [31:0] data,
  output logic [3:0]  len,
  output logic        space,
  output logic        newline,
  output logic        error
);
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, data_q, data_d;
  logic [3:0] count_q, count_d, len_q, len_d, nibble;
  logic strobe_q, strobe_d, error_q, error_d, space_q, space_d, newline_q, newline_d;
  logic is_digit, is_space, is_newline, is_term;
  ascii_classify u_cls (
    .c(uart_rxd), .is_digit(is_digit), .nibble(nibble),
    .is_space(is_space), .is_newline(is_newline)
  );
  assign is_term = is_space || is_newline;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    count_d = count_q;
    data_d = data_q;
    len_d = len_q;
    space_d = space_q;
    newline_d = newline_q;
    strobe_d = 1'b0;
    error_d = 1'b0;
    if (uart_rxd_strobe) begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            acc_d = 32'(nibble);
            count_d = 4'd1;
            state_d = DIGITS;
          end else if (!is_term) begin
            error_d = 1'b1;
            state_d = SKIP;
          end
        end
        DIGITS: begin
          if (is_digit && count_q != 4'(MAX_DIGITS)) begin
            acc_d = {acc_q[27:0], nibble};
            count_d = count_q + 4'd1;
          end else if (is_term) begin
            data_d = acc_q;
            len_d = count_q;
            space_d = is_space;
            newline_d = is_newline;
            strobe_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = SKIP;
          end
        end
        SKIP: state_d = is_term ? IDLE : SKIP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      count_q <= '0;
      data_q <= '0;
      len_q <= '0;
      space_q <= 1'b0;
      newline_q <= 1'b0;
      strobe_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      count_q <= count_d;
      data_q <= data_d;
      len_q <= len_d;
      space_q <= space_d;
      newline_q <= newline_d;
      strobe_q <= strobe_d;
      error_q <= error_d;
    end
  end
  assign strobe = strobe_q;
  assign data = data_q;
  assign len = len_q;
  assign space = space_q;
  assign newline = newline_q;
  assign error = error_q;
endmodule

// File: tb/tb_uart_rx_hexparse.sv
// tb_uart_rx_hexparse: table-driven byte stream checks on MAX_DIGITS=8 and MAX_DIGITS=4 instances
module tb_uart_rx_hexparse;
  logic clk = 1'b0, reset = 1'b1, rx_stb = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic stb8, sp8, nl8, err8, stb4, sp4, nl4, err4;
  logic [31:0] d8, d4;
  logic [3:0] l8, l4;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_hexparse #(.MAX_DIGITS(8)) dut8 (
    .clk(clk), .reset(reset), .uart_rxd_strobe(rx_stb), .uart_rxd(rxd),
    .strobe(stb8), .data(d8), .len(l8), .space(sp8), .newline(nl8), .error(err8)
  );
  uart_rx_hexparse #(.MAX_DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .uart_rxd_strobe(rx_stb), .uart_rxd(rxd),
    .strobe(stb4), .data(d4), .len(l4), .space(sp4), .newline(nl4), .error(err4)
  );

  typedef struct {
    logic m4;
    logic [7:0] b;
    logic stb, err;
    logic [31:0] d;
    logic [3:0] l;
    logic sp, nl;
  } vec_t;
  vec_t q[$];

  task automatic add(input logic m4, input logic [7:0] b, input logic stb, input logic err,
                     input logic [31:0] d, input logic [3:0] l, input logic sp, input logic nl);
    vec_t v;
    v.m4 = m4; v.b = b; v.stb = stb; v.err = err; v.d = d; v.l = l; v.sp = sp; v.nl = nl;
    q.push_back(v);
  endtask

  // bytes that must produce neither strobe nor error while outputs hold
  task automatic addq(input logic m4, input string s, input logic [31:0] d, input logic [3:0] l,
                      input logic sp, input logic nl);
    for (int i = 0; i < s.len(); i++) add(m4, s[i], 1'b0, 1'b0, d, l, sp, nl);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic m4, input logic stb, input logic err,
                         input logic [31:0] d, input logic [3:0] l, input logic sp, input logic nl);
    chk("strobe", idx, 32'(m4 ? stb4 : stb8), 32'(stb));
    chk("error", idx, 32'(m4 ? err4 : err8), 32'(err));
    chk("data", idx, m4 ? d4 : d8, d);
    chk("len", idx, 32'(m4 ? l4 : l8), 32'(l));
    chk("space", idx, 32'(m4 ? sp4 : sp8), 32'(sp));
    chk("newline", idx, 32'(m4 ? nl4 : nl8), 32'(nl));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_stb = 1'b1;
    rxd = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      send(q[i].b);
      chk_all(i, q[i].m4, q[i].stb, q[i].err, q[i].d, q[i].l, q[i].sp, q[i].nl);
    end
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  initial begin
    int na;
    addq(0, "DEADbeef", 32'h0, 4'd0, 1'b0, 1'b0);
    add(0, 8'h0A, 1'b1, 1'b0, 32'hDEADBEEF, 4'd8, 1'b0, 1'b1);
    addq(0, "1f", 32'hDEADBEEF, 4'd8, 1'b0, 1'b1);
    add(0, 8'h20, 1'b1, 1'b0, 32'h1F, 4'd2, 1'b1, 1'b0);
    addq(0, "  \r\n", 32'h1F, 4'd2, 1'b1, 1'b0);
    addq(0, "12345678", 32'h1F, 4'd2, 1'b1, 1'b0);
    add(0, "9", 1'b0, 1'b1, 32'h1F, 4'd2, 1'b1, 1'b0);
    addq(0, " 7", 32'h1F, 4'd2, 1'b1, 1'b0);
    add(0, 8'h0A, 1'b1, 1'b0, 32'h7, 4'd1, 1'b0, 1'b1);
    addq(0, "12", 32'h7, 4'd1, 1'b0, 1'b1);
    add(0, "G", 1'b0, 1'b1, 32'h7, 4'd1, 1'b0, 1'b1);
    addq(0, "45 ", 32'h7, 4'd1, 1'b0, 1'b1);
    add(0, "z", 1'b0, 1'b1, 32'h7, 4'd1, 1'b0, 1'b1);
    addq(0, "z\t", 32'h7, 4'd1, 1'b0, 1'b1);
    na = q.size();
    addq(1, "FFFF", 32'hC, 4'd1, 1'b0, 1'b1);
    add(1, 8'h09, 1'b1, 1'b0, 32'hFFFF, 4'd4, 1'b1, 1'b0);
    addq(1, "FFFF", 32'hFFFF, 4'd4, 1'b1, 1'b0);
    add(1, "F", 1'b0, 1'b1, 32'hFFFF, 4'd4, 1'b1, 1'b0);
    addq(1, " ", 32'hFFFF, 4'd4, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 0, 32'h0, 4'd0, 0, 0);
    chk_all(-1, 1, 0, 0, 32'h0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, na);
    @(posedge clk);
    #1;
    chk_all(-2, 0, 0, 0, 32'h7, 4'd1, 0, 1);

    send("A");
    send("B");
    @(negedge clk);
    reset = 1'b1;
    rxd = 8'h0A;
    @(posedge clk);
    #1;
    chk_all(-3, 0, 0, 0, 32'h0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    rx_stb = 1'b0;
    @(posedge clk);
    #1;
    chk_all(-4, 0, 0, 0, 32'h0, 4'd0, 0, 0);
    send("C");
    chk_all(-5, 0, 0, 0, 32'h0, 4'd0, 0, 0);
    send(8'h0A);
    chk_all(-6, 0, 1, 0, 32'hC, 4'd1, 0, 1);
    chk_all(-6, 1, 1, 0, 32'hC, 4'd1, 0, 1);
    @(negedge clk);
    rx_stb = 1'b0;
    @(posedge clk);
    #1;
    chk_all(-7, 0, 0, 0, 32'hC, 4'd1, 0, 1);

    run(na, q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
